// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RV32I pipeline: the data-access size encodings
// carried on the EX/MEM register and the MEM-stage load/store FSM states.
// No ports (package).
// -----------------------------------------------------------------------------
package riscv_pkg;

  // mem_size encodings; 2'd3 is reserved and treated as an illegal access
  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic for the load/store unit.
//   Store side : st_size, st_offset, rs2 -> be (byte enables), wdata (lanes)
//   Load side  : ld_size, ld_offset, ld_sign, rdata -> ldata (extended)
// The store side works on the live EX/MEM request; the load side works on the
// size/offset/sign captured when the transaction was launched.
// -----------------------------------------------------------------------------
module lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_offset,
  input  logic [31:0] rs2,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_offset,
  input  logic        ld_sign,
  input  logic [31:0] rdata,
  output logic [31:0] ldata
);

  logic [31:0] shifted;

  // Replicating the narrow store data across all lanes means the memory only
  // has to honour the byte enables; it never needs to know the offset.
  always_comb begin
    be    = 4'b1111;
    wdata = rs2;
    case (st_size)
      MEM_B: begin
        be    = 4'b0001 << st_offset;
        wdata = {4{rs2[7:0]}};
      end
      MEM_H: begin
        be    = 4'b0011 << st_offset;
        wdata = {2{rs2[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = rs2;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend; word loads ignore sign.
  always_comb begin
    shifted = rdata >> {ld_offset, 3'b000};
    ldata   = shifted;
    case (ld_size)
      MEM_B:   ldata = {{24{ld_sign & shifted[7]}}, shifted[7:0]};
      MEM_H:   ldata = {{16{ld_sign & shifted[15]}}, shifted[15:0]};
      default: ldata = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
// Memory-stage load/store unit. Runs one req/gnt/rvalid bus transaction per
// EX/MEM access and stalls the upstream pipeline while it is in flight.
//   clk, reset (async, active-low)
//   EX/MEM side : mem_read, mem_write, sign, mem_size, alu, rs2
//   Bus side    : bus_req, bus_we, bus_addr, bus_be, bus_wdata (out, registered)
//                 bus_gnt, bus_rvalid, bus_rdata (in)
//   Pipeline    : stall (comb), load_data/load_valid (registered), fault (pulse)
// -----------------------------------------------------------------------------
module mem_stage_lsu
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              sign,
  input  logic [1:0]        mem_size,
  input  logic [31:0]       alu,
  input  logic [31:0]       rs2,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              fault
);

  lsu_state_t  state_q, state_d;

  logic        access;
  logic        illegal;
  logic        launch;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  // Load-side context kept from launch so the result is independent of
  // whatever EX/MEM shows later.
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        sign_q;

  assign access  = mem_read | mem_write;
  assign illegal = (mem_read & mem_write)
                 | (mem_size == 2'd3)
                 | ((mem_size == MEM_H) & alu[0])
                 | ((mem_size == MEM_W) & (alu[1:0] != 2'b00));
  assign launch  = (state_q == IDLE) & access & ~illegal;

  // Gated with reset so the stall drops immediately when reset is asserted,
  // even if EX/MEM still shows a valid access.
  assign stall = reset & (launch | (state_q == REQ) | (state_q == WAIT));

  lsu_align u_align (
    .st_size   (mem_size),
    .st_offset (alu[1:0]),
    .rs2       (rs2),
    .be        (st_be),
    .wdata     (st_wdata),
    .ld_size   (size_q),
    .ld_offset (off_q),
    .ld_sign   (sign_q),
    .rdata     (bus_rdata),
    .ldata     (ld_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = REQ;
      REQ:     if (bus_gnt) state_d = bus_we ? DONE : WAIT;
      WAIT:    if (bus_rvalid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // fault and load_valid default low every cycle so they can only ever be
  // single-cycle pulses; bus fields are frozen between launch and the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= 4'b0000;
      bus_wdata  <= 32'h0;
      off_q      <= 2'b00;
      size_q     <= MEM_B;
      sign_q     <= 1'b0;
      load_data  <= 32'h0;
      load_valid <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fault      <= 1'b0;
      load_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (access && illegal) begin
            fault <= 1'b1;
          end else if (launch) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_write;
            bus_addr  <= {alu[ADDR_W-1:2], 2'b00};
            bus_be    <= st_be;
            bus_wdata <= st_wdata;
            off_q     <= alu[1:0];
            size_q    <= mem_size;
            sign_q    <= sign;
          end
        end
        REQ: begin
          if (bus_gnt) bus_req <= 1'b0;
        end
        WAIT: begin
          if (bus_rvalid) begin
            load_data  <= ld_data;
            load_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_lsu
// Directed scoreboard bench for mem_stage_lsu. Stimulus pushes the expected
// bus handshake / load result / fault pulse into a queue; a monitor pops and
// compares whenever the DUT presents one of those events.
// -----------------------------------------------------------------------------
module tb_mem_stage_lsu;

  localparam int EV_BUS   = 0;
  localparam int EV_LOAD  = 1;
  localparam int EV_FAULT = 2;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        sign = 1'b0;
  logic [1:0]  mem_size = 2'd0;
  logic [31:0] alu = 32'h0;
  logic [31:0] rs2 = 32'h0;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        fault;

  int  n_cmp = 0;
  int  n_err = 0;
  ev_t exp_q[$];

  mem_stage_lsu #(.ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .sign       (sign),
    .mem_size   (mem_size),
    .alu        (alu),
    .rs2        (rs2),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic pushEv(input int kind, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, input logic we, input logic [31:0] data);
    ev_t ev;
    ev.kind  = kind;
    ev.addr  = addr;
    ev.be    = be;
    ev.wdata = wdata;
    ev.we    = we;
    ev.data  = data;
    exp_q.push_back(ev);
  endtask

  task automatic handleEv(input int kind);
    ev_t ev;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL unexpected_event: got kind %0d required none at %0t", kind, $time);
    end else begin
      ev = exp_q.pop_front();
      checkOutput("event_kind", kind, ev.kind);
      if (kind == ev.kind) begin
        if (kind == EV_BUS) begin
          checkOutput("bus_addr", bus_addr, ev.addr);
          checkOutput("bus_be", {28'h0, bus_be}, {28'h0, ev.be});
          checkOutput("bus_we", {31'h0, bus_we}, {31'h0, ev.we});
          if (ev.we) checkOutput("bus_wdata", bus_wdata, ev.wdata);
        end else if (kind == EV_LOAD) begin
          checkOutput("load_data", load_data, ev.data);
        end
      end
    end
  endtask

  // Monitor: samples two time units before each rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (bus_req && bus_gnt) handleEv(EV_BUS);
      if (load_valid)         handleEv(EV_LOAD);
      if (fault)              handleEv(EV_FAULT);
    end
  end

  // Presents one EX/MEM access and plays the bus slave: gnt on REQ cycle
  // gnt_dly+1, rvalid on WAIT cycle rv_dly. Returns in the DONE cycle (or the
  // IDLE cycle for a faulting access) so a following call is back-to-back.
  task automatic applyStimulus(input string name, input logic rd, input logic wr,
                               input logic sg, input logic [1:0] sz,
                               input logic [31:0] a, input logic [31:0] d,
                               input int gnt_dly, input int rv_dly,
                               input logic [31:0] rdat, input logic exp_fault,
                               input logic [31:0] exp_addr, input logic [3:0] exp_be,
                               input logic [31:0] exp_wdata, input logic [31:0] exp_ldata,
                               input int exp_stall);
    int stall_cnt = 0;
    int req_cnt   = 0;
    int wait_cnt  = 0;
    int first_req = -1;
    bit granted   = 1'b0;
    bit stable    = 1'b1;
    bit done      = 1'b0;

    if (exp_fault) begin
      pushEv(EV_FAULT, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0);
    end else begin
      pushEv(EV_BUS, exp_addr, exp_be, exp_wdata, wr, 32'h0);
      if (rd) pushEv(EV_LOAD, 32'h0, 4'h0, 32'h0, 1'b0, exp_ldata);
    end

    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    sign      = sg;
    mem_size  = sz;
    alu       = a;
    rs2       = d;

    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      #1;
      if (stall) stall_cnt++;
      if (bus_req) begin
        if (first_req < 0) first_req = cyc;
        if (bus_addr !== exp_addr || bus_be !== exp_be || bus_we !== wr ||
            (wr && bus_wdata !== exp_wdata)) stable = 1'b0;
      end
      if (!stall) begin
        done = 1'b1;
      end else if (bus_req) begin
        if (req_cnt == gnt_dly) begin
          bus_gnt = 1'b1;
          granted = 1'b1;
        end
        req_cnt++;
      end else if (granted) begin
        wait_cnt++;
        if (wait_cnt == rv_dly) begin
          bus_rvalid = 1'b1;
          bus_rdata  = rdat;
        end
      end
      if (!done) begin
        @(posedge clk);
        #1;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        @(negedge clk);
      end
    end

    checkOutput({name, "_finished"}, {31'h0, done}, 32'h1);
    checkOutput({name, "_stall_cycles"}, stall_cnt, exp_stall);
    if (exp_fault) begin
      @(negedge clk);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      #1;
      checkOutput({name, "_no_req"}, {31'h0, bus_req}, 32'h0);
    end else begin
      checkOutput({name, "_done_req_low"}, {31'h0, bus_req}, 32'h0);
      checkOutput({name, "_first_req_cycle"}, first_req, 1);
      checkOutput({name, "_bus_stable"}, {31'h0, stable}, 32'h1);
    end
  endtask

  task automatic idleCycles(input int n);
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    $display("[TB] start");

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_bus_req", {31'h0, bus_req}, 32'h0);
    checkOutput("rst_bus_we", {31'h0, bus_we}, 32'h0);
    checkOutput("rst_bus_addr", bus_addr, 32'h0);
    checkOutput("rst_bus_be", {28'h0, bus_be}, 32'h0);
    checkOutput("rst_bus_wdata", bus_wdata, 32'h0);
    checkOutput("rst_stall", {31'h0, stall}, 32'h0);
    checkOutput("rst_load_data", load_data, 32'h0);
    checkOutput("rst_load_valid", {31'h0, load_valid}, 32'h0);
    checkOutput("rst_fault", {31'h0, fault}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Store byte at offset 3, gnt on the 2nd REQ cycle
    applyStimulus("st_b", 1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_1003, 32'h0000_00AB, 1, 0, 32'h0,
                  1'b0, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 32'h0, 3);
    idleCycles(1);

    // Load half signed / unsigned at offset 2
    applyStimulus("ld_h_s", 1'b1, 1'b0, 1'b1, 2'd1, 32'h0000_2002, 32'h0, 0, 1, 32'h8001_7FFF,
                  1'b0, 32'h0000_2000, 4'b1100, 32'h0, 32'hFFFF_8001, 3);
    idleCycles(1);
    applyStimulus("ld_h_u", 1'b1, 1'b0, 1'b0, 2'd1, 32'h0000_2002, 32'h0, 0, 1, 32'h8001_7FFF,
                  1'b0, 32'h0000_2000, 4'b1100, 32'h0, 32'h0000_8001, 3);
    idleCycles(1);

    // Illegal accesses: misaligned word, reserved size, read and write together
    applyStimulus("flt_word", 1'b1, 1'b0, 1'b0, 2'd2, 32'h0000_3001, 32'h0, 0, 1, 32'h0,
                  1'b1, 32'h0, 4'h0, 32'h0, 32'h0, 0);
    applyStimulus("flt_size3", 1'b1, 1'b0, 1'b0, 2'd3, 32'h0000_4000, 32'h0, 0, 1, 32'h0,
                  1'b1, 32'h0, 4'h0, 32'h0, 32'h0, 0);
    applyStimulus("flt_rdwr", 1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_4000, 32'h1, 0, 1, 32'h0,
                  1'b1, 32'h0, 4'h0, 32'h0, 32'h0, 0);
    idleCycles(1);

    // Load byte signed, gnt delayed 5 cycles, rvalid 3 cycles after gnt
    applyStimulus("ld_b_slow", 1'b1, 1'b0, 1'b1, 2'd0, 32'h0000_5001, 32'h0, 5, 3, 32'h1234_F6AA,
                  1'b0, 32'h0000_5000, 4'b0010, 32'h0, 32'hFFFF_FFF6, 10);
    idleCycles(1);

    // Back-to-back store half then load word, then a store word
    applyStimulus("b2b_st_h", 1'b0, 1'b1, 1'b0, 2'd1, 32'h0000_6002, 32'hDEAD_BEEF, 0, 0, 32'h0,
                  1'b0, 32'h0000_6000, 4'b1100, 32'hBEEF_BEEF, 32'h0, 2);
    applyStimulus("b2b_ld_w", 1'b1, 1'b0, 1'b1, 2'd2, 32'h0000_7000, 32'h0, 0, 2, 32'hCAFE_F00D,
                  1'b0, 32'h0000_7000, 4'b1111, 32'h0, 32'hCAFE_F00D, 4);
    applyStimulus("st_w", 1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_8000, 32'h0102_0304, 2, 0, 32'h0,
                  1'b0, 32'h0000_8000, 4'b1111, 32'h0102_0304, 32'h0, 4);
    idleCycles(2);
    checkOutput("ld_hold", load_data, 32'hCAFE_F00D);

    // Reset asserted while waiting for read data
    pushEv(EV_BUS, 32'h0000_9000, 4'b1111, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    mem_read = 1'b1;
    mem_size = 2'd2;
    alu      = 32'h0000_9000;
    sign     = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rstw_req_up", {31'h0, bus_req}, 32'h1);
    bus_gnt = 1'b1;
    @(posedge clk);
    #1;
    bus_gnt = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rstw_wait_stall", {31'h0, stall}, 32'h1);
    reset    = 1'b0;
    mem_read = 1'b0;
    #1;
    checkOutput("rstw_bus_req", {31'h0, bus_req}, 32'h0);
    checkOutput("rstw_stall", {31'h0, stall}, 32'h0);
    checkOutput("rstw_load_valid", {31'h0, load_valid}, 32'h0);
    checkOutput("rstw_load_data", load_data, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h5555_5555;
    @(posedge clk);
    #1;
    bus_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("stray_load_data", load_data, 32'h0);
    checkOutput("stray_stall", {31'h0, stall}, 32'h0);

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
